// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: collects completed results from several functional units and
// hands at most NUM_WB of them per cycle to the ROB. The units are served in
// rotating priority order. The chosen results appear in registered writeback
// slots one cycle after their handshake.
module rob_wb_arbiter #(
    parameter int NUM_FU = 3,
    parameter int NUM_WB = 2,
    parameter int IDX_W  = 5,
    parameter int OPC_W  = 7,
    parameter int VAL_W  = 6,
    parameter int CNT_W  = 16,
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    rob_stall_i,
    input  logic [NUM_FU-1:0]       fu_valid_i,
    output logic [NUM_FU-1:0]       fu_ready_o,
    input  logic [NUM_FU*IDX_W-1:0] fu_rob_idx_i,
    input  logic [NUM_FU*OPC_W-1:0] fu_opcode_i,
    input  logic [NUM_FU*VAL_W-1:0] fu_val_i,
    output logic [NUM_WB-1:0]       wb_valid_o,
    output logic [NUM_WB*IDX_W-1:0] wb_rob_idx_o,
    output logic [NUM_WB*OPC_W-1:0] wb_opcode_o,
    output logic [NUM_WB*VAL_W-1:0] wb_val_o,
    output logic [PTR_W-1:0]        rr_ptr_o,
    output logic [CNT_W-1:0]        contention_cnt_o,
    output logic                    dup_idx_err_o
);

    // One extra bit so that rr_ptr + scan offset cannot overflow before the wrap.
    localparam int SUM_W = PTR_W + 1;

    // Unpacked views of the per-FU payload buses.
    logic [IDX_W-1:0] fu_idx [NUM_FU];
    logic [OPC_W-1:0] fu_opc [NUM_FU];
    logic [VAL_W-1:0] fu_val [NUM_FU];

    // Registered state.
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [PTR_W-1:0] rr_ptr_next;
    logic [NUM_WB-1:0] wb_valid_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             dup_reg;

    // Scan order: position s holds FU (rr_ptr + s) mod NUM_FU.
    logic [PTR_W-1:0]  scan_fu [NUM_FU];
    logic [NUM_FU-1:0] scan_valid;

    // Grant results.
    logic              arb_en;
    logic [NUM_FU-1:0] fu_grant;
    logic [NUM_WB-1:0] slot_used;
    logic [PTR_W-1:0]  slot_src [NUM_WB];
    logic [PTR_W-1:0]  last_fu;
    logic              any_grant;
    logic              contended;
    logic              dup_hit;
    int                grant_cnt;

    // Per-slot combinational payload selected from the granted FU.
    logic [IDX_W-1:0] slot_idx [NUM_WB];
    logic [OPC_W-1:0] slot_opc [NUM_WB];
    logic [VAL_W-1:0] slot_val [NUM_WB];

    genvar gi;

    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_unpack
            assign fu_idx[gi] = fu_rob_idx_i[gi*IDX_W +: IDX_W];
            assign fu_opc[gi] = fu_opcode_i[gi*OPC_W +: OPC_W];
            assign fu_val[gi] = fu_val_i[gi*VAL_W +: VAL_W];
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_scan
            logic [SUM_W-1:0] pos_sum;
            assign pos_sum = {1'b0, rr_ptr_reg} + SUM_W'(gi);
            assign scan_fu[gi] = (pos_sum >= SUM_W'(NUM_FU)) ?
                                 PTR_W'(pos_sum - SUM_W'(NUM_FU)) :
                                 pos_sum[PTR_W-1:0];
            assign scan_valid[gi] = fu_valid_i[scan_fu[gi]];
        end
    endgenerate

    // Grants are only issued out of reset and when the ROB can take results.
    assign arb_en = rst_n & ~flush_i & ~rob_stall_i;

    // Walk the scan order and hand out slots to the first NUM_WB valid FUs.
    always_comb begin
        fu_grant  = '0;
        slot_used = '0;
        last_fu   = rr_ptr_reg;
        grant_cnt = 0;
        for (int w = 0; w < NUM_WB; w++) begin
            slot_src[w] = '0;
        end
        for (int s = 0; s < NUM_FU; s++) begin
            if (arb_en && scan_valid[s] && (grant_cnt < NUM_WB)) begin
                for (int w = 0; w < NUM_WB; w++) begin
                    if (grant_cnt == w) begin
                        slot_used[w] = 1'b1;
                        slot_src[w]  = scan_fu[s];
                    end
                end
                for (int k = 0; k < NUM_FU; k++) begin
                    if (scan_fu[s] == PTR_W'(k)) begin
                        fu_grant[k] = 1'b1;
                    end
                end
                last_fu   = scan_fu[s];
                grant_cnt = grant_cnt + 1;
            end
        end
    end

    assign any_grant  = |slot_used;
    assign contended  = ($countones(fu_valid_i) > grant_cnt);
    assign fu_ready_o = fu_grant;

    // Next priority: the FU just after the last one granted, wrapping at NUM_FU.
    assign rr_ptr_next = (last_fu == PTR_W'(NUM_FU - 1)) ? '0 : last_fu + 1'b1;

    generate
        for (gi = 0; gi < NUM_WB; gi++) begin : g_slot_mux
            assign slot_idx[gi] = fu_idx[slot_src[gi]];
            assign slot_opc[gi] = fu_opc[slot_src[gi]];
            assign slot_val[gi] = fu_val[slot_src[gi]];
        end
    endgenerate

    // Detect two slots in the same cycle targeting the same ROB entry.
    always_comb begin
        dup_hit = 1'b0;
        for (int a = 0; a < NUM_WB; a++) begin
            for (int b = a + 1; b < NUM_WB; b++) begin
                if (slot_used[a] && slot_used[b] && (slot_idx[a] == slot_idx[b])) begin
                    dup_hit = 1'b1;
                end
            end
        end
    end

    // Control state: slot valids, priority pointer, contention counter, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg <= '0;
            rr_ptr_reg   <= '0;
            cnt_reg      <= '0;
            dup_reg      <= 1'b0;
        end else begin
            // slot_used is already empty during flush or stall.
            wb_valid_reg <= slot_used;
            if (flush_i) begin
                rr_ptr_reg <= '0;
            end else if (any_grant) begin
                rr_ptr_reg <= rr_ptr_next;
            end
            if (contended && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (dup_hit) begin
                dup_reg <= 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_WB; gi++) begin : g_slot_reg
            logic [IDX_W-1:0] idx_reg;
            logic [OPC_W-1:0] opc_reg;
            logic [VAL_W-1:0] val_reg;

            // Slot payload: loaded when the slot is used, otherwise held.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    idx_reg <= '0;
                    opc_reg <= '0;
                    val_reg <= '0;
                end else if (slot_used[gi]) begin
                    idx_reg <= slot_idx[gi];
                    opc_reg <= slot_opc[gi];
                    val_reg <= slot_val[gi];
                end
            end

            assign wb_rob_idx_o[gi*IDX_W +: IDX_W] = idx_reg;
            assign wb_opcode_o[gi*OPC_W +: OPC_W]  = opc_reg;
            assign wb_val_o[gi*VAL_W +: VAL_W]     = val_reg;
        end
    endgenerate

    assign wb_valid_o       = wb_valid_reg;
    assign rr_ptr_o         = rr_ptr_reg;
    assign contention_cnt_o = cnt_reg;
    assign dup_idx_err_o    = dup_reg;

endmodule
